// File: rtl/umi_encode_tx.sv
// umi_encode_tx: encodes typed host requests into UMI opcodes, registers them onto a
// valid/ready output and tracks outstanding response-bearing requests against a credit limit.
module umi_encode_tx #(
    parameter int AW     = 64,
    parameter int DW     = 256,
    parameter int MAXOUT = 4,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_type,
    input  logic [3:0]    req_atype,
    input  logic [AW-1:0] req_dstaddr,
    input  logic [AW-1:0] req_srcaddr,
    input  logic [DW-1:0] req_data,
    output logic          umi_out_valid,
    input  logic          umi_out_ready,
    output logic [6:0]    umi_out_cmd,
    output logic          umi_out_write,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    input  logic          resp_valid,
    output logic [CW-1:0] outstanding,
    output logic          err_invalid,
    output logic          err_underflow
);
    localparam logic [7:0] OP_READ_REQUEST = 8'h02;
    localparam logic [7:0] OP_WRITE_POSTED = 8'h01;
    localparam logic [7:0] OP_WRITE_SIGNAL = 8'h03;
    localparam logic [7:0] OP_WRITE_STREAM = 8'h05;
    localparam logic [7:0] OP_WRITE_ACK    = 8'h07;
    localparam logic [CW-1:0] MAX_C        = CW'(MAXOUT);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    cmd_q;
    logic          write_q, err_invalid_q, err_underflow_q;
    logic [AW-1:0] dst_q, src_q;
    logic [DW-1:0] data_q;
    logic          legal, needs_resp, accept, load, inc, dec;
    logic [7:0]    opcode;

    always_comb begin
        legal      = (req_type < 3'd5) | (req_type == 3'd5 && req_atype <= 4'd8);
        needs_resp = legal & (req_type == 3'd0 | req_type == 3'd3 | req_type == 3'd5);
        // Atomic opcodes share the low nibble 0x9; the op selector sits in the high nibble.
        opcode     = req_type == 3'd0 ? OP_READ_REQUEST :
                     req_type == 3'd1 ? OP_WRITE_POSTED :
                     req_type == 3'd2 ? OP_WRITE_SIGNAL :
                     req_type == 3'd3 ? OP_WRITE_ACK    :
                     req_type == 3'd4 ? OP_WRITE_STREAM : {req_atype, 4'h9};
        req_ready  = (state_q == EMPTY | umi_out_ready) & (!needs_resp | cnt_q < MAX_C);
        accept     = req_valid & req_ready;
        load       = accept & legal;
        inc        = load & needs_resp;
        dec        = resp_valid & cnt_q != '0;
        state_d    = load ? FULL : (state_q == FULL && !umi_out_ready) ? FULL : EMPTY;
        cnt_d      = (inc && !resp_valid) ? cnt_q + 1'b1 : (dec && !inc) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q         <= EMPTY;
            cnt_q           <= '0;
            cmd_q           <= '0;
            write_q         <= 1'b0;
            dst_q           <= '0;
            src_q           <= '0;
            data_q          <= '0;
            err_invalid_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            err_invalid_q   <= accept & !legal;
            err_underflow_q <= err_underflow_q | (resp_valid & cnt_q == '0 & !inc);
            if (load) begin
                cmd_q   <= opcode[7:1];
                write_q <= opcode[0];
                dst_q   <= req_dstaddr;
                src_q   <= req_srcaddr;
                data_q  <= req_type == 3'd0 ? '0 : req_data;
            end
        end
    end

    assign umi_out_valid   = state_q == FULL;
    assign umi_out_cmd     = cmd_q;
    assign umi_out_write   = write_q;
    assign umi_out_dstaddr = dst_q;
    assign umi_out_srcaddr = src_q;
    assign umi_out_data    = data_q;
    assign outstanding     = cnt_q;
    assign err_invalid     = err_invalid_q;
    assign err_underflow   = err_underflow_q;
endmodule

// File: tb/tb_umi_encode_tx.sv
// tb_umi_encode_tx: scoreboard bench for umi_encode_tx with a two-credit limit.
module tb_umi_encode_tx;
    localparam int AW = 64, DW = 256, MAXOUT = 2, CW = 2;

    typedef struct {
        logic [6:0]    cmd;
        logic          wr;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } pkt_t;

    logic          clk, nreset, req_valid, req_ready, umi_out_valid, umi_out_ready;
    logic [2:0]    req_type;
    logic [3:0]    req_atype;
    logic [AW-1:0] req_dstaddr, req_srcaddr, umi_out_dstaddr, umi_out_srcaddr;
    logic [DW-1:0] req_data, umi_out_data;
    logic [6:0]    umi_out_cmd;
    logic          umi_out_write, resp_valid, err_invalid, err_underflow;
    logic [CW-1:0] outstanding;

    int   n_cmp = 0;
    int   n_bad = 0;
    pkt_t q[$];

    umi_encode_tx #(.AW(AW), .DW(DW), .MAXOUT(MAXOUT), .CW(CW)) dut (
        .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_atype(req_atype), .req_dstaddr(req_dstaddr),
        .req_srcaddr(req_srcaddr), .req_data(req_data), .umi_out_valid(umi_out_valid),
        .umi_out_ready(umi_out_ready), .umi_out_cmd(umi_out_cmd), .umi_out_write(umi_out_write),
        .umi_out_dstaddr(umi_out_dstaddr), .umi_out_srcaddr(umi_out_srcaddr),
        .umi_out_data(umi_out_data), .resp_valid(resp_valid), .outstanding(outstanding),
        .err_invalid(err_invalid), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_op(input int t, input int a);
        case (t)
            0: return 8'h02;
            1: return 8'h01;
            2: return 8'h03;
            3: return 8'h07;
            4: return 8'h05;
            default: case (a)
                0: return 8'h09;
                1: return 8'h19;
                2: return 8'h29;
                3: return 8'h39;
                4: return 8'h49;
                5: return 8'h59;
                6: return 8'h69;
                7: return 8'h79;
                default: return 8'h89;
            endcase
        endcase
    endfunction

    always @(negedge clk) begin
        if (nreset && umi_out_valid && umi_out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_extra: got cmd=%h dst=%h with no packet expected", umi_out_cmd, umi_out_dstaddr);
            end else begin
                pkt_t p;
                p = q.pop_front();
                if ({umi_out_cmd, umi_out_write, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} !==
                    {p.cmd, p.wr, p.dst, p.src, p.data}) begin
                    n_bad++;
                    $display("FAIL sb_pkt: got cmd=%h w=%b dst=%h src=%h data=%h want cmd=%h w=%b dst=%h src=%h data=%h",
                             umi_out_cmd, umi_out_write, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
                             p.cmd, p.wr, p.dst, p.src, p.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int t, input int a, input logic [AW-1:0] d, input logic [AW-1:0] s,
                         input logic [DW-1:0] x, input bit push);
        pkt_t       p;
        logic [7:0] op;
        req_valid   = 1'b1;
        req_type    = t[2:0];
        req_atype   = a[3:0];
        req_dstaddr = d;
        req_srcaddr = s;
        req_data    = x;
        op          = exp_op(t, a);
        p.cmd       = op[7:1];
        p.wr        = op[0];
        p.dst       = d;
        p.src       = s;
        p.data      = t == 0 ? '0 : x;
        if (push) q.push_back(p);
    endtask

    task automatic test_reset();
        nreset = 1'b0; req_valid = 1'b0; req_type = '0; req_atype = '0; req_dstaddr = '0;
        req_srcaddr = '0; req_data = '0; umi_out_ready = 1'b1; resp_valid = 1'b0;
        repeat (3) tick();
        nreset = 1'b1;
        tick();
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_cmp++; if (umi_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", umi_out_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        n_cmp++; if ({err_invalid, err_underflow} !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b want 00", {err_invalid, err_underflow}); end
        n_cmp++; if ({umi_out_cmd, umi_out_dstaddr} !== '0) begin n_bad++; $display("FAIL rst_bus: got cmd=%h dst=%h want 0", umi_out_cmd, umi_out_dstaddr); end
    endtask

    task automatic test_read();
        drive(0, 0, 64'h1000, 64'h2000, {8{32'hdeadbeef}}, 1);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL read_ready: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (umi_out_valid !== 1'b1) begin n_bad++; $display("FAIL read_valid: got %b want 1", umi_out_valid); end
        n_cmp++; if ({umi_out_cmd, umi_out_write} !== 8'h02) begin n_bad++; $display("FAIL read_op: got %h want 02", {umi_out_cmd, umi_out_write}); end
        n_cmp++; if (umi_out_data !== '0) begin n_bad++; $display("FAIL read_data: got %h want 0", umi_out_data); end
        n_cmp++; if (outstanding !== 2'd1) begin n_bad++; $display("FAIL read_cnt: got %0d want 1", outstanding); end
        tick();
        n_cmp++; if (umi_out_valid !== 1'b0) begin n_bad++; $display("FAIL read_drain: got %b want 0", umi_out_valid); end
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL read_resp: got %0d want 0", outstanding); end
    endtask

    task automatic test_credit();
        drive(0, 0, 64'hA000, 64'h1, '0, 1);
        tick();
        drive(0, 0, 64'hB000, 64'h2, '0, 1);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL credit_second: got %b want 1", req_ready); end
        tick();
        drive(0, 0, 64'hC000, 64'h3, '0, 1);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL credit_third_held: got %b want 0", req_ready); end
        tick();
        n_cmp++; if (outstanding !== 2'd2) begin n_bad++; $display("FAIL credit_full: got %0d want 2", outstanding); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL credit_still_held: got %b want 0", req_ready); end
        resp_valid = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL credit_same_cycle: got %b want 0", req_ready); end
        tick();
        resp_valid = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL credit_release: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (outstanding !== 2'd2) begin n_bad++; $display("FAIL credit_refill: got %0d want 2", outstanding); end
        n_cmp++; if (umi_out_valid !== 1'b1) begin n_bad++; $display("FAIL credit_third_out: got %b want 1", umi_out_valid); end
        resp_valid = 1'b1;
        repeat (2) tick();
        resp_valid = 1'b0;
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL credit_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_stall();
        umi_out_ready = 1'b0;
        drive(1, 0, 64'h5555, 64'h6666, {4{64'h0123456789abcdef}}, 1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (umi_out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, umi_out_valid); end
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, req_ready); end
            n_cmp++;
            if ({umi_out_cmd, umi_out_write, umi_out_dstaddr, umi_out_data} !== {8'h01, 64'h5555, {4{64'h0123456789abcdef}}}) begin
                n_bad++; $display("FAIL stall_stable[%0d]: got op=%h dst=%h", i, {umi_out_cmd, umi_out_write}, umi_out_dstaddr);
            end
            tick();
        end
        umi_out_ready = 1'b1;
        tick();
        n_cmp++; if (umi_out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", umi_out_valid); end
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL stall_cnt: got %0d want 0", outstanding); end
    endtask

    task automatic test_atomic();
        drive(5, 8, 64'h7000, 64'h7100, 256'h42, 1);
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({umi_out_cmd, umi_out_write} !== 8'h89) begin n_bad++; $display("FAIL atomic_swap: got %h want 89", {umi_out_cmd, umi_out_write}); end
        n_cmp++; if (outstanding !== 2'd1) begin n_bad++; $display("FAIL atomic_cnt: got %0d want 1", outstanding); end
        drive(5, 12, 64'h7200, 64'h7300, 256'h9, 0);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL atomic_bad_ready: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (err_invalid !== 1'b1) begin n_bad++; $display("FAIL atomic_bad_err: got %b want 1", err_invalid); end
        n_cmp++; if (umi_out_valid !== 1'b0) begin n_bad++; $display("FAIL atomic_bad_drop: got %b want 0", umi_out_valid); end
        n_cmp++; if (outstanding !== 2'd1) begin n_bad++; $display("FAIL atomic_bad_cnt: got %0d want 1", outstanding); end
        tick();
        n_cmp++; if (err_invalid !== 1'b0) begin n_bad++; $display("FAIL atomic_err_pulse: got %b want 0", err_invalid); end
        drive(6, 0, 64'h7400, 64'h7500, '0, 0);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (err_invalid !== 1'b1) begin n_bad++; $display("FAIL type6_err: got %b want 1", err_invalid); end
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL atomic_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_back_to_back();
        int types[6] = '{1, 2, 4, 3, 5, 1};
        for (int i = 0; i < 6; i++) begin
            drive(types[i], i, 64'h9000 + 64'(i), 64'h9100 + 64'(i), 256'(32'hc0de0000 + i), 1);
            tick();
            n_cmp++; if (umi_out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, umi_out_valid); end
        end
        req_valid = 1'b0;
        tick();
        n_cmp++; if (umi_out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %b want 0", umi_out_valid); end
        n_cmp++; if (outstanding !== 2'd2) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 2", outstanding); end
        resp_valid = 1'b1;
        repeat (2) tick();
        resp_valid = 1'b0;
    endtask

    task automatic test_underflow();
        n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL uf_pre: got %b want 0", err_underflow); end
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_set: got %b want 1", err_underflow); end
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL uf_cnt: got %0d want 0", outstanding); end
        repeat (2) tick();
        n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
        umi_out_ready = 1'b0;
        drive(0, 0, 64'hE000, 64'hE100, '0, 1);
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({umi_out_valid, outstanding} !== 3'b101) begin n_bad++; $display("FAIL uf_full: got %b want 101", {umi_out_valid, outstanding}); end
        #2;
        nreset = 1'b0;
        #1;
        q.delete();
        n_cmp++; if (umi_out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", umi_out_valid); end
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL arst_cnt: got %0d want 0", outstanding); end
        n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL arst_uf: got %b want 0", err_underflow); end
        n_cmp++; if ({umi_out_cmd, umi_out_dstaddr} !== '0) begin n_bad++; $display("FAIL arst_bus: got cmd=%h dst=%h want 0", umi_out_cmd, umi_out_dstaddr); end
        repeat (2) tick();
        nreset = 1'b1;
        umi_out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_credit();
        test_stall();
        test_atomic();
        test_back_to_back();
        test_underflow();
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d packets pending want 0", q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
